// File: rtl/puf_challenge_ctrl_pkg.sv
// Shared FSM state encoding, counter sizing and constants for the PUF challenge sequencer.
// Pure declarations only: no logic, no latency, no flow control.
package puf_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, HOLD} puf_ctrl_state_t;

  localparam int TXN_CNT_W = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/puf_challenge_ctrl_if.sv
// Host-side bundle of the PUF sequencer: request level plus the challenge/response valid/ready pair.
// The slave side (the sequencer) holds chal_out/resp_data/resp_err stable while resp_valid waits on resp_ready.
interface puf_challenge_ctrl_if #(
  parameter int N_CB   = 64,
  parameter int N_RESP = 8
);
  logic              req;
  logic [N_CB-1:0]   chal_out;
  logic              resp_valid;
  logic              resp_ready;
  logic [N_RESP-1:0] resp_data;
  logic              resp_err;

  modport master (
    output req, resp_ready,
    input  chal_out, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req, resp_ready,
    output chal_out, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/puf_challenge_ctrl.sv
// Refills the TRNG challenge after a request, launches one PUF evaluation, returns challenge/response.
// Request-to-resp_valid >= N_CB/N_RNG+3 cycles; the pair is held until resp_ready, one transaction in flight.
module puf_challenge_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int N_CB    = 64,
  parameter int N_RNG   = 8,
  parameter int N_RESP  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CB-1:0]      chal_in,
  input  logic                 puf_done,
  input  logic [N_RESP-1:0]    puf_resp,
  output logic                 puf_start,
  output logic                 busy,
  output logic [TXN_CNT_W-1:0] txn_cnt,
  puf_challenge_ctrl_if.slave  host
);

  localparam int FILL_CYC = N_CB / N_RNG;
  localparam int FILL_W   = cnt_w(FILL_CYC);
  localparam int WAIT_W   = cnt_w(TIMEOUT);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  puf_ctrl_state_t      state, state_nxt;
  logic [FILL_W-1:0]    fill_cnt, fill_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
  logic [N_CB-1:0]      chal_nxt;
  logic [N_RESP-1:0]    data_nxt;
  logic                 err_nxt;
  logic [TXN_CNT_W-1:0] txn_nxt;
  logic                 start_nxt, valid_nxt, busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      fill_cnt        <= '0;
      wait_cnt        <= '0;
      puf_start       <= 1'b0;
      busy            <= 1'b0;
      txn_cnt         <= '0;
      host.chal_out   <= '0;
      host.resp_valid <= 1'b0;
      host.resp_data  <= '0;
      host.resp_err   <= 1'b0;
    end else begin
      state           <= state_nxt;
      fill_cnt        <= fill_nxt;
      wait_cnt        <= wait_nxt;
      puf_start       <= start_nxt;
      busy            <= busy_nxt;
      txn_cnt         <= txn_nxt;
      host.chal_out   <= chal_nxt;
      host.resp_valid <= valid_nxt;
      host.resp_data  <= data_nxt;
      host.resp_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    wait_nxt  = wait_cnt;
    chal_nxt  = host.chal_out;
    data_nxt  = host.resp_data;
    err_nxt   = host.resp_err;
    txn_nxt   = txn_cnt;

    unique case (state)
      IDLE: begin
        if (host.req) begin
          state_nxt = FILL;
          fill_nxt  = '0;
        end
      end
      // Hold off the launch until a full register's worth of bits has arrived after the request.
      FILL: begin
        if (fill_cnt == FILL_LAST) begin
          chal_nxt  = chal_in;
          state_nxt = ISSUE;
        end else begin
          fill_nxt = fill_cnt + 1'b1;
        end
      end
      ISSUE: begin
        wait_nxt  = '0;
        state_nxt = WAIT;
      end
      // A done pulse in the final allowed cycle still beats the timeout.
      WAIT: begin
        if (puf_done) begin
          data_nxt  = puf_resp;
          err_nxt   = 1'b0;
          state_nxt = HOLD;
        end else if (wait_cnt == WAIT_LAST) begin
          data_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (host.resp_valid && host.resp_ready) begin
          txn_nxt   = txn_cnt + 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    start_nxt = (state_nxt == ISSUE);
    valid_nxt = (state_nxt == HOLD);
    busy_nxt  = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Directed bench for puf_challenge_ctrl: vector table for the first transaction, hand sequences for corner cases.
module tb_puf_challenge_ctrl;
  localparam int N_CB     = 64;
  localparam int N_RNG    = 8;
  localparam int N_RESP   = 8;
  localparam int TIMEOUT  = 255;
  localparam int FILL_CYC = N_CB / N_RNG;
  localparam logic [63:0] CBASE = 64'hC0DE_0000_0000_0000;

  typedef struct {
    logic        req;
    logic        done;
    logic [7:0]  resp;
    logic        ready;
    logic        e_start;
    logic        e_busy;
    logic        e_valid;
    logic        e_err;
    logic [7:0]  e_data;
    logic [63:0] e_chal;
    logic [15:0] e_txn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] chal_in;
  logic        puf_done;
  logic [7:0]  puf_resp;
  logic        puf_start;
  logic        busy;
  logic [15:0] txn_cnt;

  int nvec = 0;
  int nmis = 0;
  logic [63:0] prev_chal;
  logic [63:0] ec;
  vec_t vt [15];

  always #5 clk = ~clk;

  puf_challenge_ctrl_if #(.N_CB(N_CB), .N_RESP(N_RESP)) hif ();

  puf_challenge_ctrl #(
    .N_CB(N_CB), .N_RNG(N_RNG), .N_RESP(N_RESP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .chal_in(chal_in), .puf_done(puf_done), .puf_resp(puf_resp),
    .puf_start(puf_start), .busy(busy), .txn_cnt(txn_cnt), .host(hif.slave)
  );

  function automatic vec_t mk(logic rq, logic dn, logic [7:0] rs, logic rd,
                              logic st, logic bs, logic vl, logic er,
                              logic [7:0] dt, logic [63:0] ch, logic [15:0] tx);
    vec_t v;
    v.req = rq; v.done = dn; v.resp = rs; v.ready = rd;
    v.e_start = st; v.e_busy = bs; v.e_valid = vl; v.e_err = er;
    v.e_data = dt; v.e_chal = ch; v.e_txn = tx;
    return v;
  endfunction

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    prev_chal = chal_in;
    chal_in   = chal_in + 64'h0001_0002_0003_0004;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, 64'(puf_start), 0);
    chk({tag, "_busy"},  64'(busy), 0);
    chk({tag, "_valid"}, 64'(hif.resp_valid), 0);
    chk({tag, "_err"},   64'(hif.resp_err), 0);
    chk({tag, "_chal"},  hif.chal_out, 0);
    chk({tag, "_data"},  64'(hif.resp_data), 0);
    chk({tag, "_txn"},   64'(txn_cnt), 0);
  endtask

  // From IDLE: one-cycle request, wait (bounded) for the launch, return at the first WAIT cycle.
  task automatic start_txn(output logic [63:0] exp_chal);
    int n;
    hif.req = 1'b1;
    cyc();
    hif.req = 1'b0;
    n = 1;
    while (!puf_start && n < 20) begin
      cyc();
      n++;
    end
    chk("issue_latency", 64'(n), 64'(FILL_CYC + 1));
    exp_chal = prev_chal;
    chk("chal_latch", hif.chal_out, exp_chal);
    cyc();
    chk("start_one_cycle", 64'(puf_start), 0);
  endtask

  task automatic handshake(input logic [15:0] exp_txn);
    hif.resp_ready = 1'b1;
    cyc();
    hif.resp_ready = 1'b0;
    chk("hs_valid_drop", 64'(hif.resp_valid), 0);
    chk("hs_busy", 64'(busy), 0);
    chk("hs_txn", 64'(txn_cnt), 64'(exp_txn));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; hif.req = 1'b0; hif.resp_ready = 1'b0;
    puf_done = 1'b0; puf_resp = '0; chal_in = '0; prev_chal = '0;

    // req at cycle 0; stray done pulses in FILL (5) and ISSUE (9); real done at 12.
    vt[0]  = mk(1, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[1]  = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[2]  = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[3]  = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[4]  = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[5]  = mk(0, 1, 8'h11, 0,  0, 1, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[6]  = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[7]  = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[8]  = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 64'h0,     16'd0);
    vt[9]  = mk(0, 1, 8'h22, 0,  1, 1, 0, 0, 8'h00, CBASE + 8, 16'd0);
    vt[10] = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, CBASE + 8, 16'd0);
    vt[11] = mk(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, CBASE + 8, 16'd0);
    vt[12] = mk(0, 1, 8'hA5, 0,  0, 1, 0, 0, 8'h00, CBASE + 8, 16'd0);
    vt[13] = mk(0, 0, 8'h00, 1,  0, 1, 1, 0, 8'hA5, CBASE + 8, 16'd0);
    vt[14] = mk(0, 0, 8'h00, 0,  0, 0, 0, 0, 8'hA5, CBASE + 8, 16'd1);

    cyc();
    cyc();
    chk_reset("por");
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      hif.req = vt[i].req; puf_done = vt[i].done; puf_resp = vt[i].resp;
      hif.resp_ready = vt[i].ready; chal_in = CBASE + 64'(i);
      chk($sformatf("v%0d_start", i), 64'(puf_start), 64'(vt[i].e_start));
      chk($sformatf("v%0d_busy", i),  64'(busy), 64'(vt[i].e_busy));
      chk($sformatf("v%0d_valid", i), 64'(hif.resp_valid), 64'(vt[i].e_valid));
      chk($sformatf("v%0d_chal", i),  hif.chal_out, vt[i].e_chal);
      chk($sformatf("v%0d_txn", i),   64'(txn_cnt), 64'(vt[i].e_txn));
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_data", i), 64'(hif.resp_data), 64'(vt[i].e_data));
        chk($sformatf("v%0d_err", i),  64'(hif.resp_err), 64'(vt[i].e_err));
      end
      cyc();
    end
    hif.req = 1'b0; puf_done = 1'b0; puf_resp = '0; hif.resp_ready = 1'b0;

    // Timeout with no done: resp_valid exactly TIMEOUT cycles after WAIT entry.
    start_txn(ec);
    k = 0;
    while (!hif.resp_valid && k < 400) begin
      cyc();
      k++;
    end
    chk("timeout_latency", 64'(k), 64'(TIMEOUT));
    chk("timeout_err", 64'(hif.resp_err), 1);
    chk("timeout_data", 64'(hif.resp_data), 0);
    chk("timeout_chal", hif.chal_out, ec);
    handshake(16'd2);

    // Done in the last allowed WAIT cycle wins over the timeout.
    start_txn(ec);
    repeat (TIMEOUT - 1) cyc();
    chk("edge_not_early", 64'(hif.resp_valid), 0);
    puf_done = 1'b1; puf_resp = 8'h3C;
    cyc();
    puf_done = 1'b0;
    chk("edge_valid", 64'(hif.resp_valid), 1);
    chk("edge_err", 64'(hif.resp_err), 0);
    chk("edge_data", 64'(hif.resp_data), 64'h3C);
    handshake(16'd3);

    // Back-pressure: 20 stalled HOLD cycles with req/done toggling.
    start_txn(ec);
    puf_done = 1'b1; puf_resp = 8'h5A;
    cyc();
    puf_done = 1'b0;
    chk("stall_first_valid", 64'(hif.resp_valid), 1);
    for (int i = 0; i < 20; i++) begin
      hif.req = (i % 2 == 1); puf_done = (i % 2 == 0); puf_resp = 8'hFF;
      cyc();
      chk("stall_valid", 64'(hif.resp_valid), 1);
      chk("stall_chal", hif.chal_out, ec);
      chk("stall_data", 64'(hif.resp_data), 64'h5A);
      chk("stall_err", 64'(hif.resp_err), 0);
      chk("stall_start", 64'(puf_start), 0);
      chk("stall_txn", 64'(txn_cnt), 3);
    end
    hif.req = 1'b0; puf_done = 1'b0;
    handshake(16'd4);
    cyc();
    chk("stall_req_dropped", 64'(busy), 0);

    // Reset in the middle of WAIT, then a late done must be ignored.
    start_txn(ec);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset("rst_wait");
    puf_done = 1'b1; puf_resp = 8'h77;
    cyc();
    puf_done = 1'b0;
    cyc();
    chk("rst_wait_late_done_valid", 64'(hif.resp_valid), 0);
    chk("rst_wait_late_done_busy", 64'(busy), 0);

    // Reset in HOLD together with resp_ready: no handshake counted.
    start_txn(ec);
    puf_done = 1'b1; puf_resp = 8'h66;
    cyc();
    puf_done = 1'b0;
    chk("hold_pre_rst_valid", 64'(hif.resp_valid), 1);
    cyc();
    rst = 1'b1; hif.resp_ready = 1'b1;
    cyc();
    rst = 1'b0; hif.resp_ready = 1'b0;
    chk_reset("rst_hold");
    puf_done = 1'b1;
    cyc();
    puf_done = 1'b0;
    cyc();
    chk("rst_hold_late_done", 64'(hif.resp_valid), 0);

    // Transaction counter wrap from 0xFFFF.
    start_txn(ec);
    puf_done = 1'b1; puf_resp = 8'h99;
    cyc();
    puf_done = 1'b0;
    chk("wrap_valid", 64'(hif.resp_valid), 1);
    force dut.txn_cnt = 16'hFFFF;
    cyc();
    release dut.txn_cnt;
    chk("wrap_preload", 64'(txn_cnt), 64'hFFFF);
    handshake(16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
